// File: rtl/data_mem_responder_pkg.sv
// Shared defines for the MEM-stage data-memory responder: datapath widths,
// default base address, wait-counter width and FSM state encoding.
package data_mem_responder_pkg;

  localparam int REGISTER_LEN   = 32;
  localparam int ADDRESS_LEN    = 32;
  localparam int DMEM_BASE_ADDR = 1024;
  // Holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15.
  localparam int DMEM_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// dmem_array: single-port word store. The write lands on the clock edge and
// the read is a combinational lookup, so the responder can capture the read
// word on the same edge it would commit a write. Contents are never reset.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);

  logic [W-1:0] mem_q [DEPTH];

  // Synchronous word write; no reset so stored data survives a pipeline reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= din;
  end

  assign dout = mem_q[idx];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory behind the MEM stage. A request
// seen in IDLE is latched, held for WAIT_CYCLES wait states, and completes on
// the edge into DONE (array write + read_data_out load). ready_out low is the
// pipeline freeze.
// Optional build macro DMEM_RANGE_CHECK_EN: out-of-range accesses are
// suppressed, read back as 0 and flagged on range_err_out during DONE.
// Without it the word index wraps modulo DEPTH (DEPTH is a power of two).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int                     DEPTH       = 64,
  parameter int                     WAIT_CYCLES = 3,
  parameter logic [ADDRESS_LEN-1:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read_in,
  input  logic                    mem_write_in,
  input  logic [ADDRESS_LEN-1:0]  address_in,
  input  logic [REGISTER_LEN-1:0] write_data_in,
  output logic [REGISTER_LEN-1:0] read_data_out,
  output logic                    ready_out
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic                    range_err_out
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : DMEM_CNT_W'(WAIT_CYCLES - 1);

  dmem_state_e             state_q, state_d;
  logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDRESS_LEN-1:0]  addr_q, addr_d;
  logic [REGISTER_LEN-1:0] wdata_q, wdata_d;
  logic [REGISTER_LEN-1:0] rdata_q, rdata_d;

  logic                    req;
  logic                    commit;
  logic                    txn_wr;
  logic [ADDRESS_LEN-1:0]  txn_addr;
  logic [REGISTER_LEN-1:0] txn_wdata;
  logic [ADDRESS_LEN-1:0]  off;
  logic [AW-1:0]           idx;
  logic                    oor;
  logic                    arr_we;
  logic [REGISTER_LEN-1:0] arr_dout;
  logic                    unused_off;

  assign req = mem_read_in | mem_write_in;

  // FSM next state, wait counter, request latch and ready_out.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ready_out = 1'b1;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_out = ~req;
        if (req) begin
          // Write wins when both strobes are high.
          wr_d    = mem_write_in;
          addr_d  = address_in;
          wdata_d = write_data_in;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_DONE;
            commit  = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        ready_out = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        ready_out = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address decode and completion datapath. With zero wait states the access
  // commits straight out of IDLE, so the live inputs are used there.
  always_comb begin
    txn_wr    = (state_q == ST_IDLE) ? mem_write_in  : wr_q;
    txn_addr  = (state_q == ST_IDLE) ? address_in    : addr_q;
    txn_wdata = (state_q == ST_IDLE) ? write_data_in : wdata_q;
    off       = txn_addr - BASE_ADDR;
    idx       = off[AW+1:2];
`ifdef DMEM_RANGE_CHECK_EN
    oor       = (txn_addr < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH));
`else
    oor       = 1'b0;
`endif
    // Never write while reset is held: a reset discards the in-flight store.
    arr_we    = commit & txn_wr & ~oor & rst;
    rdata_d   = rdata_q;
    if (commit) rdata_d = oor ? '0 : (txn_wr ? txn_wdata : arr_dout);
  end

  // Only the word-index bits of the offset feed the array.
  assign unused_off = ^off;

  // State, counter, latched request and load data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign read_data_out = rdata_q;

`ifdef DMEM_RANGE_CHECK_EN
  logic rerr_q, rerr_d;

  assign rerr_d = commit & oor;

  // Range error flag, high only during the DONE cycle of the bad access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rerr_q <= 1'b0;
    else      rerr_q <= rerr_d;
  end

  assign range_err_out = rerr_q;
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (REGISTER_LEN)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .idx  (idx),
    .din  (txn_wdata),
    .dout (arr_dout)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed plus random accesses with a word-array
// reference model; expected completions go into a queue and a negedge monitor
// checks each DONE cycle (data, stall length, range flag) and the idle state.
// A second instance with zero wait states gets a short directed sequence.
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam int          WAIT  = 3;
  localparam logic [31:0] BASE  = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        r0 = 1'b0, w0 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0;
  logic [31:0] rdata0;
  logic        ready0;
`ifdef DMEM_RANGE_CHECK_EN
  logic        rerr, rerr0;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .mem_read_in(rd), .mem_write_in(wr),
    .address_in(addr), .write_data_in(wdata),
    .read_data_out(rdata), .ready_out(ready)
`ifdef DMEM_RANGE_CHECK_EN
    , .range_err_out(rerr)
`endif
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .rst(rst), .mem_read_in(r0), .mem_write_in(w0),
    .address_in(a0), .write_data_in(d0),
    .read_data_out(rdata0), .ready_out(ready0)
`ifdef DMEM_RANGE_CHECK_EN
    , .range_err_out(rerr0)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rdata = '0;
  int          stall = 0;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Monitor: count stall cycles, check each completion against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      stall      = 0;
      last_rdata = '0;
    end else if (rd | wr) begin
      if (!ready) begin
        stall++;
      end else if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_rdata", rdata, e.rdata);
        check("stall_cycles", 32'(stall), 32'(WAIT + 1));
`ifdef DMEM_RANGE_CHECK_EN
        check("done_range_err", {31'd0, rerr}, {31'd0, e.err});
`endif
        last_rdata = e.rdata;
        stall      = 0;
      end
    end else begin
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_hold_rdata", rdata, last_rdata);
`ifdef DMEM_RANGE_CHECK_EN
      check("idle_range_err", {31'd0, rerr}, 32'd0);
`endif
    end
  end

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = ready;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Model the access from the address rules, queue the result, drive it.
  task automatic issue(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t        e;
    logic [31:0] word;
    bit          oor;
    int          idx;
    word = (a - BASE) >> 2;
    oor  = (a < BASE) || (word >= 32'(DEPTH));
    idx  = int'(word % 32'(DEPTH));
    e.err = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    if (oor) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else begin
      if (w) model[idx] = d;
      e.rdata = w ? d : model[idx];
    end
`else
    if (oor) e.err = 1'b0;
    if (w) model[idx] = d;
    e.rdata = w ? d : model[idx];
`endif
    sb.push_back(e);
    rd = r; wr = w; addr = a; wdata = d;
    wait_done();
  endtask

  task automatic idle(input int n);
    rd = 1'b0; wr = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Zero-wait-state instance: one stall cycle, data present in DONE.
  task automatic t0(input bit r, input bit w, input logic [31:0] a,
                    input logic [31:0] d, input logic [31:0] exp);
    r0 = r; w0 = w; a0 = a; d0 = d;
    @(negedge clk);
    check("w0_stall", {31'd0, ready0}, 32'd0);
    @(negedge clk);
    check("w0_done_ready", {31'd0, ready0}, 32'd1);
    check("w0_rdata", rdata0, exp);
    @(posedge clk);
    #1;
    r0 = 1'b0; w0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_rdata", rdata, 32'd0);
    check("reset_ready0", {31'd0, ready0}, 32'd1);
    check("reset_rdata0", rdata0, 32'd0);
    rst = 1'b1;
    idle(1);

    for (int i = 0; i < DEPTH; i++) issue(0, 1, BASE + 32'(4 * i), 32'hC000_0000 | 32'(i));
    idle(1);

    issue(0, 1, 32'd1028, 32'hDEAD_BEEF);
    idle(1);
    issue(1, 0, 32'd1028, 32'h0);
    idle(2);
    issue(0, 1, 32'd1024, 32'h11);
    issue(1, 0, 32'd1024, 32'h0);
    idle(1);
    issue(1, 1, 32'd1032, 32'h55);
    issue(1, 0, 32'd1032, 32'h0);

    // Reset in the middle of a write's wait states discards the store.
    idle(1);
    wr = 1'b1; addr = 32'd1036; wdata = 32'h99;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0; wr = 1'b0;
    #1;
    check("midreset_ready", {31'd0, ready}, 32'd1);
    check("midreset_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    issue(1, 0, 32'd1036, 32'h0);

    issue(0, 1, BASE + 32'(4 * DEPTH), 32'hA1B2_C3D4);
    issue(1, 0, BASE + 32'(4 * DEPTH), 32'h0);
    issue(1, 0, BASE, 32'h0);

    for (int n = 0; n < 120; n++) begin
      int          gap, op, k;
      logic [31:0] a;
      gap = int'($urandom_range(0, 2));
      if (gap != 0) idle(gap);
      op = int'($urandom_range(0, 2));
      k  = int'($urandom_range(0, DEPTH + 7));
      a  = BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
      issue(op != 1, op != 0, a, $urandom);
    end
    idle(2);

    t0(0, 1, 32'd1024, 32'h77, 32'h77);
    t0(0, 1, 32'd1028, 32'h66, 32'h66);
    t0(1, 0, 32'd1024, 32'h0, 32'h77);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
